alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Command-side driver for the 8-bit combinational ALU: accepts 16-bit instructions over valid/ready,
//  reads operands from a local 4x8 register file, drives ALU operands and select codes, samples the
//  ALU result, writes it back and returns it over a valid/ready response channel. Sits between a
//  command source (testbench/CPU stub) and the ALU instance.
// PARAMETERS
//  DATA_W   8  operand/result width
//  REG_AW   2  register-file address width (2**REG_AW registers)
//  ALU_LAT  1  cycles operands/selects are held before the ALU output is sampled (>=1)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  cmd_valid  in   1       instruction present
//  cmd_ready  out  1       controller can accept
//  cmd_instr  in   16      [15:12] op, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm (LDI only)
//  alu_a      out  DATA_W  ALU operand A
//  alu_b      out  DATA_W  ALU operand B
//  alu_s1     out  2       ALU class select: 2'b00 arithmetic, 2'b01 logic
//  alu_s2     out  3       ALU arithmetic select
//  alu_s3     out  4       ALU logic select
//  alu_o      in   DATA_W  ALU result
//  rsp_valid  out  1       result present
//  rsp_ready  in   1       consumer accepts result
//  rsp_data   out  DATA_W  result written to rd
//  rsp_err    out  1       1 = illegal opcode, no writeback
//  ops_done   out  8       count of completed responses, wraps 255->0
// BEHAVIOUR
//  Opcode map (op -> s1/s2/s3): 0 ADD 00/001, 1 SUB 00/010, 2 MUL 00/011 (low 8 bits), 3 AND 01/0000,
//   4 OR 01/0001, 5 NAND 01/0010, 6 NOT(rs1) 01/0011, 7 NOR 01/0100, 8 XOR 01/0101, 9 XNOR 01/0110,
//   10 SHL(rs1) 01/0111, 11 SHR(rs2) 01/1000, 12 CMPEQ 01/1001 (result 8'h01/8'h00), 13 LDI rd<=imm,
//   14 NOP (result 0, no writeback), 15 illegal.
//  FSM IDLE -> ISSUE -> RESP -> IDLE; LDI/NOP/illegal go IDLE -> RESP directly.
//  IDLE: cmd_ready=1; accept on cmd_valid&cmd_ready (cycle T); latch instr, read rs1/rs2.
//  ISSUE: alu_a=R[rs1], alu_b=R[rs2], selects per map, held constant ALU_LAT cycles (down-counter);
//   on last ISSUE cycle sample alu_o, write R[rd], load rsp_data; rsp_valid=1 from T+ALU_LAT+1.
//  RESP: rsp_valid held, rsp_data/rsp_err stable until rsp_valid&rsp_ready; ops_done++ on that
//   handshake; next cycle IDLE (cmd_ready=1). No command accepted while in ISSUE/RESP.
//  LDI: R[rd]<=imm, rsp_data=imm, rsp_valid at T+1. Illegal: rsp_err=1, rsp_data=0, no write.
//  Operands read at accept; rd==rs1/rs2 uses pre-write value.
//  Outside ISSUE: alu_a=alu_b=0, alu_s1=2'b00, alu_s2=3'b000, alu_s3=4'b0000.
//  Reset (any state, incl. mid-ISSUE/RESP): state=IDLE, all R[i]=0, cmd_ready=0 during rst then 1,
//   rsp_valid=0, rsp_data=0, rsp_err=0, ops_done=0, ALU outputs at idle values; in-flight op dropped.
// STRUCTURE
//  Package alu_issue_pkg: opcode localparams (OP_ADD..OP_ILL), select-code constants, FSM state
//   encodings, instruction field positions.
//  Sub-module alu_op_decode: combinational op -> {s1,s2,s3,writes_rd,uses_alu,illegal}.
//  Top holds FSM, latency counter, register file, response regs, ops_done.
// TESTING
//  1 LDI R0=8'h0C, LDI R1=8'h05, ADD R2=R0+R1 -> rsp_data 8'h11, rsp_valid exactly T+2 (ALU_LAT=1).
//  2 SUB R3=R1-R0 -> 8'hF9; MUL R0=8'h20*8'h10 -> 8'h00 (truncation); CMPEQ equal regs -> 8'h01.
//  3 Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, ops_done unchanged.
//  4 op=15 -> rsp_err=1, rsp_data=0, all registers unchanged; op=14 -> rsp_data=0, no write.
//  5 Assert rst during ISSUE of ADD -> next cycle all outputs at reset values, R[*]=0, no response.
//  6 256 back-to-back NOPs with rsp_ready=1 -> ops_done wraps to 0; ALU selects idle between ops.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_pkg: opcodes, ALU select codes, FSM states and instruction field positions
package alu_issue_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_NAND  = 4'd5;
    localparam logic [3:0] OP_NOT   = 4'd6;
    localparam logic [3:0] OP_NOR   = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_XNOR  = 4'd9;
    localparam logic [3:0] OP_SHL   = 4'd10;
    localparam logic [3:0] OP_SHR   = 4'd11;
    localparam logic [3:0] OP_CMPEQ = 4'd12;
    localparam logic [3:0] OP_LDI   = 4'd13;
    localparam logic [3:0] OP_NOP   = 4'd14;
    localparam logic [3:0] OP_ILL   = 4'd15;

    localparam logic [1:0] S1_ARITH = 2'b00;
    localparam logic [1:0] S1_LOGIC = 2'b01;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 6;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] s1;
        logic [2:0] s2;
        logic [3:0] s3;
        logic       writes_rd;
        logic       uses_alu;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: command, response and ALU-facing signals of the issue controller
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [15:0]       cmd_instr;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [1:0]        alu_s1;
    logic [2:0]        alu_s2;
    logic [3:0]        alu_s3;
    logic [DATA_W-1:0] alu_o;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [7:0]        ops_done;

    modport slave (
        input  cmd_valid, cmd_instr, alu_o, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_s1, alu_s2, alu_s3, rsp_valid, rsp_data, rsp_err, ops_done
    );

    modport master (
        output cmd_valid, cmd_instr, alu_o, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_s1, alu_s2, alu_s3, rsp_valid, rsp_data, rsp_err, ops_done
    );
endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// alu_op_decode: maps a 4-bit opcode onto ALU selects and writeback/illegal flags
module alu_op_decode
    import alu_issue_pkg::*;
(
    input  logic [3:0] i_op,
    output dec_t       o_dec
);
    logic w_logic;

    assign w_logic         = (i_op >= OP_AND) && (i_op <= OP_CMPEQ);
    assign o_dec.uses_alu  = i_op <= OP_CMPEQ;
    assign o_dec.s1        = w_logic ? S1_LOGIC : S1_ARITH;
    // arithmetic ops and logic ops are each contiguous, so the select is an offset of the opcode
    assign o_dec.s2        = (i_op <= OP_MUL) ? i_op[2:0] + 3'd1 : 3'd0;
    assign o_dec.s3        = w_logic ? i_op - OP_AND : 4'd0;
    assign o_dec.writes_rd = i_op <= OP_LDI;
    assign o_dec.illegal   = i_op == OP_ILL;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues instructions to an external combinational ALU from a local register file
// and returns each result over a valid/ready response channel.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REG_AW  = 2,
    parameter int ALU_LAT = 1
) (
    input logic            clk,
    input logic            rst,
    alu_issue_ctrl_if.slave bus
);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_rf [2**REG_AW];
    logic [DATA_W-1:0] r_a, r_b, r_rsp_data;
    logic [3:0]        r_op;
    logic [REG_AW-1:0] r_rd;
    logic [CW-1:0]     r_cnt;
    logic              r_rsp_err;
    logic [7:0]        r_ops_done;
    logic [3:0]        w_op;
    logic              w_accept, w_issue, w_last, w_done;
    dec_t              w_dec;

    // while idle the decoder looks at the incoming instruction, otherwise at the latched one
    assign w_op     = (r_state == S_IDLE) ? bus.cmd_instr[OP_LSB +: 4] : r_op;
    assign w_accept = bus.cmd_valid && bus.cmd_ready;
    assign w_issue  = r_state == S_ISSUE;
    assign w_last   = w_issue && (r_cnt == '0);
    assign w_done   = (r_state == S_RESP) && bus.rsp_ready;

    alu_op_decode u_dec (
        .i_op  (w_op),
        .o_dec (w_dec)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? (w_dec.uses_alu ? S_ISSUE : S_RESP) : S_IDLE;
            S_ISSUE: w_next = w_last ? S_RESP : S_ISSUE;
            S_RESP:  w_next = bus.rsp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_NOP;
            r_rd       <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_ops_done <= '0;
            for (int i = 0; i < 2**REG_AW; i++) r_rf[i] <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op  <= w_op;
                r_rd  <= bus.cmd_instr[RD_LSB +: REG_AW];
                r_a   <= r_rf[bus.cmd_instr[RS1_LSB +: REG_AW]];
                r_b   <= r_rf[bus.cmd_instr[RS2_LSB +: REG_AW]];
                r_cnt <= CW'(ALU_LAT - 1);
                if (!w_dec.uses_alu) begin
                    r_rsp_data <= w_dec.writes_rd ? DATA_W'(bus.cmd_instr[IMM_LSB +: 8]) : '0;
                    r_rsp_err  <= w_dec.illegal;
                    if (w_dec.writes_rd) r_rf[bus.cmd_instr[RD_LSB +: REG_AW]] <= DATA_W'(bus.cmd_instr[IMM_LSB +: 8]);
                end
            end
            if (w_last) begin
                r_rsp_data <= bus.alu_o;
                r_rsp_err  <= 1'b0;
                if (w_dec.writes_rd) r_rf[r_rd] <= bus.alu_o;
            end else if (w_issue) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_done) r_ops_done <= r_ops_done + 8'd1;
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE) && !rst;
    assign bus.alu_a     = w_issue ? r_a : '0;
    assign bus.alu_b     = w_issue ? r_b : '0;
    assign bus.alu_s1    = w_issue ? w_dec.s1 : S1_ARITH;
    assign bus.alu_s2    = w_issue ? w_dec.s2 : 3'd0;
    assign bus.alu_s3    = w_issue ? w_dec.s3 : 4'd0;
    assign bus.rsp_valid = r_state == S_RESP;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.ops_done  = r_ops_done;
endmodule
